decoder_onehot_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder for driving strobe, enable and scan lines from a single select bus. It replaces fixed-width combinational decoders wherever the design needs a timed strobe or an autonomous rotating one-hot line, such as display column scanning or round-robin enables. It supports three modes: latched decode, fixed-length pulse, and auto-scan with programmable dwell. It sits between control logic and the physical select lines.

---
 rtl/decoder_onehot_seq.sv | 132 +++++++++++++
 tb/tb_decoder_onehot_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with latched, fixed-length pulse and
// auto-scan modes, for strobe/enable/scan-line generation.
module decoder_onehot_seq #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned DWELL      = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    busy
);

  localparam int unsigned N      = 1 << SEL_W;
  localparam int unsigned MaxLen = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;

  localparam logic [1:0] ModeLatch = 2'b00;
  localparam logic [1:0] ModePulse = 2'b01;
  localparam logic [1:0] ModeScan  = 2'b10;
  localparam logic [1:0] ModeRsvd  = 2'b11;

  typedef enum logic [1:0] {StIdle, StHold, StPulse, StScan} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      out_q, out_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              mode_vld_q, mode_vld_d;
  logic [N-1:0]      sel_hot;
  logic              go_idle;

  assign sel_hot = {{(N-1){1'b0}}, 1'b1} << sel;

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    mode_d     = mode;
    mode_vld_d = en && (mode != ModeRsvd);
    // Disable, reserved mode, or the first cycle of a new (or newly enabled) mode.
    go_idle    = !en || (mode == ModeRsvd) || !mode_vld_q || (mode != mode_q);

    if (!go_idle) begin
      case (mode)
        ModeLatch: begin
          if (load) begin
            state_d = StHold;
            out_d   = sel_hot;
            idx_d   = sel;
            busy_d  = 1'b0;
          end
        end
        ModePulse: begin
          if (state_q == StPulse) begin
            if (cnt_q == '0) go_idle = 1'b1;
            else             cnt_d   = cnt_q - CntW'(1);
          end else if (load) begin
            state_d = StPulse;
            out_d   = sel_hot;
            idx_d   = sel;
            busy_d  = 1'b1;
            cnt_d   = CntW'(PULSE_LEN - 1);
          end
        end
        ModeScan: begin
          if (state_q != StScan) begin
            state_d = StScan;
            out_d   = {{(N-1){1'b0}}, 1'b1};
            idx_d   = '0;
            busy_d  = 1'b1;
            cnt_d   = CntW'(DWELL - 1);
          end else if (load) begin
            out_d = sel_hot;
            idx_d = sel;
            cnt_d = CntW'(DWELL - 1);
          end else if (cnt_q == '0) begin
            out_d = {out_q[N-2:0], out_q[N-1]};
            idx_d = idx_q + SEL_W'(1);
            cnt_d = CntW'(DWELL - 1);
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d = StIdle;
      out_d   = '0;
      idx_d   = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      out_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= ModeLatch;
      mode_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      mode_vld_q <= mode_vld_d;
    end
  end

  assign out  = out_q ^ {N{ACTIVE_LOW}};
  assign idx  = idx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Scoreboard bench for decoder_onehot_seq: two configurations share stimulus,
// a behavioural model predicts each cycle's outputs and a monitor checks them.
module tb_decoder_onehot_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  sel = 4'd0;
  logic        load = 1'b0;

  logic [15:0] out_a;
  logic [3:0]  idx_a;
  logic        busy_a;
  logic [3:0]  out_b;
  logic [1:0]  idx_b;
  logic        busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(4), .PULSE_LEN(4), .DWELL(3), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .en (en), .mode (mode), .sel (sel), .load (load),
    .out (out_a), .idx (idx_a), .busy (busy_a)
  );

  decoder_onehot_seq #(.SEL_W(2), .PULSE_LEN(2), .DWELL(2), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .en (en), .mode (mode), .sel (sel[1:0]), .load (load),
    .out (out_b), .idx (idx_b), .busy (busy_b)
  );

  // Model: what the lines are doing (off/held/pulsing/scanning), where, and for how long.
  typedef enum int {MIdle, MHold, MPulse, MScan} act_e;
  typedef struct {
    act_e act;
    int   pos;
    int   left;
    int   last_mode;
    bit   mode_seen;
  } mdl_t;

  typedef struct {
    logic [15:0] out_a;
    logic [3:0]  idx_a;
    logic        busy_a;
    logic [3:0]  out_b;
    logic [1:0]  idx_b;
    logic        busy_b;
  } exp_t;

  exp_t exp_q[$];
  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.act = MIdle; m.pos = 0; m.left = 0; m.last_mode = 0; m.mode_seen = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit e, input int md, input bit ld,
                                    input int s_raw, input int n, input int plen,
                                    input int dwell);
    mdl_t r = m;
    int s = s_raw % n;
    if (!e || md == 3) begin
      r.act = MIdle; r.mode_seen = 1'b0;
    end else if (!m.mode_seen || md != m.last_mode) begin
      r.act = MIdle; r.mode_seen = 1'b1; r.last_mode = md;
    end else if (md == 0) begin
      if (ld) begin r.act = MHold; r.pos = s; end
    end else if (md == 1) begin
      if (m.act == MPulse) begin
        r.left = m.left - 1;
        if (r.left == 0) r.act = MIdle;
      end else if (ld) begin
        r.act = MPulse; r.pos = s; r.left = plen;
      end
    end else begin
      if (m.act != MScan) begin
        r.act = MScan; r.pos = 0; r.left = dwell;
      end else if (ld) begin
        r.pos = s; r.left = dwell;
      end else begin
        r.left = m.left - 1;
        if (r.left == 0) begin r.pos = (m.pos + 1) % n; r.left = dwell; end
      end
    end
    if (r.act == MIdle) r.pos = 0;
    return r;
  endfunction

  function automatic int mdl_out(input mdl_t m, input int n, input bit al);
    int o = (m.act == MIdle) ? 0 : (1 << m.pos);
    if (al) o = ~o & ((1 << n) - 1);
    return o;
  endfunction

  function automatic exp_t mdl_expect(input mdl_t a, input mdl_t b);
    exp_t x;
    x.out_a  = 16'(mdl_out(a, 16, 1'b0));
    x.idx_a  = 4'(a.pos);
    x.busy_a = (a.act == MPulse) || (a.act == MScan);
    x.out_b  = 4'(mdl_out(b, 4, 1'b1));
    x.idx_b  = 2'(b.pos);
    x.busy_b = (b.act == MPulse) || (b.act == MScan);
    return x;
  endfunction

  // Reference model: one expected entry per rising edge.
  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ma = mdl_reset();
        mb = mdl_reset();
      end else begin
        ma = mdl_step(ma, en, int'(mode), load, int'(sel), 16, 4, 3);
        mb = mdl_step(mb, en, int'(mode), load, int'(sel), 4, 2, 2);
      end
      exp_q.push_back(mdl_expect(ma, mb));
    end
  end

  // Monitor: compare on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (out_a !== e.out_a || idx_a !== e.idx_a || busy_a !== e.busy_a) begin
          bad++;
          $display("FAIL sb_a t=%0t out/idx/busy got %h/%0d/%b want %h/%0d/%b", $time,
                   out_a, idx_a, busy_a, e.out_a, e.idx_a, e.busy_a);
        end
        total++;
        if (out_b !== e.out_b || idx_b !== e.idx_b || busy_b !== e.busy_b) begin
          bad++;
          $display("FAIL sb_b t=%0t out/idx/busy got %h/%0d/%b want %h/%0d/%b", $time,
                   out_b, idx_b, busy_b, e.out_b, e.idx_b, e.busy_b);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // Apply inputs for one rising edge; returns at the following falling edge.
  task automatic drive(input bit e, input logic [1:0] md, input bit ld, input logic [3:0] s);
    en = e; mode = md; load = ld; sel = s;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] cur_mode;
    repeat (2) @(negedge clk);
    chk("reset_out_a", int'(out_a), 32'h0000);
    chk("reset_out_b", int'(out_b), 32'hF);
    rst_n = 1'b1;

    // LATCH
    repeat (3) drive(1'b1, 2'b00, 1'b0, 4'd0);
    drive(1'b1, 2'b00, 1'b1, 4'd9);
    chk("latch_9", int'(out_a), 32'h0200);
    repeat (20) drive(1'b1, 2'b00, 1'b0, 4'd0);
    chk("latch_hold", int'(out_a), 32'h0200);
    drive(1'b1, 2'b00, 1'b1, 4'd0);
    chk("latch_0", int'(out_a), 32'h0001);

    // PULSE: retrigger ignored, then accepted right after busy falls
    repeat (2) drive(1'b1, 2'b01, 1'b0, 4'd0);
    drive(1'b1, 2'b01, 1'b1, 4'd15);
    chk("pulse_out", int'(out_a), 32'h8000);
    chk("pulse_busy", int'(busy_a), 1);
    drive(1'b1, 2'b01, 1'b1, 4'd3);
    chk("pulse_ignore", int'(out_a), 32'h8000);
    repeat (2) drive(1'b1, 2'b01, 1'b0, 4'd0);
    chk("pulse_last", int'(busy_a), 1);
    drive(1'b1, 2'b01, 1'b0, 4'd0);
    chk("pulse_end", int'(busy_a), 0);
    drive(1'b1, 2'b01, 1'b1, 4'd7);
    chk("pulse_retrig", int'(out_a), 32'h0080);
    repeat (5) drive(1'b1, 2'b01, 1'b0, 4'd0);

    // SCAN: jump, run, en drop, restart
    repeat (2) drive(1'b1, 2'b10, 1'b0, 4'd0);
    chk("scan_start", int'(idx_a), 0);
    chk("scan_busy", int'(busy_a), 1);
    drive(1'b1, 2'b10, 1'b1, 4'd2);
    chk("scan_jump", int'(idx_a), 2);
    repeat (12) drive(1'b1, 2'b10, 1'b0, 4'd0);
    drive(1'b0, 2'b10, 1'b0, 4'd0);
    chk("scan_en_off", int'(out_a), 0);
    repeat (2) drive(1'b1, 2'b10, 1'b0, 4'd0);
    chk("scan_restart", int'(out_a), 32'h0001);

    // Mode change with simultaneous load
    repeat (2) drive(1'b1, 2'b01, 1'b0, 4'd0);
    drive(1'b1, 2'b01, 1'b1, 4'd4);
    drive(1'b1, 2'b00, 1'b1, 4'd6);
    chk("modechg_out", int'(out_a), 0);
    drive(1'b1, 2'b00, 1'b1, 4'd5);
    chk("modechg_load", int'(out_a), 32'h0020);

    // Asynchronous reset mid-scan
    repeat (6) drive(1'b1, 2'b10, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_a", int'(out_a), 0);
    chk("arst_out_b", int'(out_b), 32'hF);
    chk("arst_idx_busy", int'({idx_a, busy_a, idx_b, busy_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with sticky modes
    cur_mode = 2'b10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 19) != 0, cur_mode, $urandom_range(0, 9) < 3,
            4'($urandom_range(0, 15)));
    end
    drive(1'b0, 2'b00, 1'b0, 4'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
